// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared widths and FSM state encoding for the wave mixer
package wave_pkg;

    localparam int SND_W  = 16;
    localparam int VOL_W  = 8;
    localparam int PROD_W = 25;
    localparam int ACC_W  = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/mix_sat.sv
// rtl/mix_sat.sv - arithmetic right shift of an accumulator, then clamp to signed 16 bits
module mix_sat
    import wave_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [SND_W-1:0] o_snd
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = 20'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -20'sd32768;

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = i_acc >>> SHIFT;
        if (shifted > SAT_MAX) begin
            o_snd = 16'sh7FFF;
        end else if (shifted < SAT_MIN) begin
            o_snd = -16'sh8000;
        end else begin
            o_snd = shifted[SND_W-1:0];
        end
    end

endmodule

// File: rtl/wave_mixer.sv
// rtl/wave_mixer.sv - time-multiplexed volume-scaled mixer of up to 8 sample channels
module wave_mixer
    import wave_pkg::*;
#(
    parameter int CHANNELS  = 8,
    parameter int MIX_SHIFT = 0
) (
    input  logic                      I_CLK,
    input  logic                      I_RST,
    input  logic                      I_SAMPLE_STB,
    input  logic [SND_W*CHANNELS-1:0] I_CH_SND,
    input  logic [VOL_W*CHANNELS-1:0] I_CH_VOL,
    input  logic [CHANNELS-1:0]       I_CH_EN,
    output logic [SND_W-1:0]          O_SND,
    output logic                      O_VALID,
    output logic                      O_BUSY,
    output logic                      O_OVERRUN
);

    localparam int SLOT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

    state_e                      state_q, state_d;
    logic [SLOT_W-1:0]           slot_q, slot_d;
    logic [SND_W*CHANNELS-1:0]   snd_snap_q, snd_snap_d;
    logic [VOL_W*CHANNELS-1:0]   vol_snap_q, vol_snap_d;
    logic [CHANNELS-1:0]         en_snap_q, en_snap_d;
    logic signed [PROD_W-1:0]    product_q, product_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [SND_W-1:0]     snd_out_q, snd_out_d;
    logic                        overrun_q, overrun_d;

    logic signed [SND_W-1:0]     cur_snd;
    logic [VOL_W-1:0]            cur_vol;
    logic                        cur_en;
    logic signed [VOL_W:0]       cur_vol_s;
    logic signed [PROD_W-1:0]    mul;
    logic signed [ACC_W-1:0]     acc_sum;
    logic signed [SND_W-1:0]     sat_snd;

    mix_sat #(
        .SHIFT (MIX_SHIFT)
    ) u_mix_sat (
        .i_acc (acc_sum),
        .o_snd (sat_snd)
    );

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        snd_snap_d = snd_snap_q;
        vol_snap_d = vol_snap_q;
        en_snap_d  = en_snap_q;
        product_d  = product_q;
        acc_d      = acc_q;
        snd_out_d  = snd_out_q;
        cur_snd    = '0;
        cur_vol    = '0;
        cur_en     = 1'b0;

        for (int k = 0; k < CHANNELS; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                cur_snd = snd_snap_q[SND_W*k +: SND_W];
                cur_vol = vol_snap_q[VOL_W*k +: VOL_W];
                cur_en  = en_snap_q[k];
            end
        end

        // Volume is unsigned; a zero MSB keeps it positive in the signed multiply.
        cur_vol_s = {1'b0, cur_vol};
        mul       = PROD_W'(cur_snd) * PROD_W'(cur_vol_s);
        // Dropping the low 8 product bits floors toward -inf; the term fits in 17 bits.
        acc_sum   = acc_q + ACC_W'(product_q >>> 8);

        overrun_d = overrun_q | (I_SAMPLE_STB && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (I_SAMPLE_STB) begin
                    snd_snap_d = I_CH_SND;
                    vol_snap_d = I_CH_VOL;
                    en_snap_d  = I_CH_EN;
                    acc_d      = '0;
                    product_d  = '0;
                    slot_d     = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                product_d = cur_en ? mul : '0;
                acc_d     = acc_sum;
                slot_d    = slot_q + SLOT_W'(1);
                if (slot_q == LAST_SLOT) begin
                    slot_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Result is registered here so it is visible together with O_VALID in OUT.
                acc_d     = acc_sum;
                snd_out_d = sat_snd;
                state_d   = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            snd_snap_q <= '0;
            vol_snap_q <= '0;
            en_snap_q  <= '0;
            product_q  <= '0;
            acc_q      <= '0;
            snd_out_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            snd_snap_q <= snd_snap_d;
            vol_snap_q <= vol_snap_d;
            en_snap_q  <= en_snap_d;
            product_q  <= product_d;
            acc_q      <= acc_d;
            snd_out_q  <= snd_out_d;
            overrun_q  <= overrun_d;
        end
    end

    assign O_SND     = snd_out_q;
    assign O_VALID   = (state_q == OUT);
    assign O_BUSY    = (state_q != IDLE);
    assign O_OVERRUN = overrun_q;

endmodule

// File: tb/tb_wave_mixer.sv
// tb/tb_wave_mixer.sv - directed self-checking bench for wave_mixer
module tb_wave_mixer;

    logic         clk = 1'b0;
    logic         rst;
    logic         stb;
    logic [127:0] ch_snd;
    logic [63:0]  ch_vol;
    logic [7:0]   ch_en;

    logic [15:0]  o_snd, o_snd3;
    logic         o_valid, o_busy, o_overrun;
    logic         o_valid3, o_busy3, o_overrun3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wave_mixer #(.CHANNELS(8), .MIX_SHIFT(0)) dut (
        .I_CLK(clk), .I_RST(rst), .I_SAMPLE_STB(stb),
        .I_CH_SND(ch_snd), .I_CH_VOL(ch_vol), .I_CH_EN(ch_en),
        .O_SND(o_snd), .O_VALID(o_valid), .O_BUSY(o_busy), .O_OVERRUN(o_overrun)
    );

    wave_mixer #(.CHANNELS(8), .MIX_SHIFT(3)) dut3 (
        .I_CLK(clk), .I_RST(rst), .I_SAMPLE_STB(stb),
        .I_CH_SND(ch_snd), .I_CH_VOL(ch_vol), .I_CH_EN(ch_en),
        .O_SND(o_snd3), .O_VALID(o_valid3), .O_BUSY(o_busy3), .O_OVERRUN(o_overrun3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe in the current cycle, then follow the pass until O_VALID (bounded) and step into IDLE.
    task automatic do_pass(output int lat, output logic [15:0] snd, output logic [15:0] snd3);
        lat  = -1;
        snd  = 16'hxxxx;
        snd3 = 16'hxxxx;
        stb  = 1'b1;
        tick();
        stb  = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (o_valid) begin
                lat  = c;
                snd  = o_snd;
                snd3 = o_snd3;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; stb = 1'b0; ch_snd = '0; ch_vol = '0; ch_en = '0;
        tick(); tick();
        checks++; if (o_snd !== 16'h0000) begin failures++; $display("FAIL reset_snd got=%h exp=0000", o_snd); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", o_overrun); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        ch_snd = '0; ch_snd[15:0] = 16'h1000;
        ch_vol = {8{8'hFF}};
        ch_en  = 8'h01;
        stb = 1'b1;
        tick();
        stb = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            checks++; if (o_busy !== (c <= 10)) begin failures++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, o_busy, (c <= 10)); end
            checks++; if (o_valid !== (c == 10)) begin failures++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", c, o_valid, (c == 10)); end
            if (c == 10) begin
                checks++; if (o_snd !== 16'h0FF0) begin failures++; $display("FAIL single_snd got=%h exp=0ff0", o_snd); end
            end
            tick();
        end
    endtask

    task automatic test_cancel_floor();
        int lat; logic [15:0] s, s3;
        ch_snd = '0; ch_snd[15:0] = 16'd1000; ch_snd[31:16] = 16'hFC18;
        ch_vol = {8{8'd128}};
        ch_en  = 8'h03;
        do_pass(lat, s, s3);
        checks++; if (lat !== 10) begin failures++; $display("FAIL cancel_latency got=%0d exp=10", lat); end
        checks++; if (s !== 16'h0000) begin failures++; $display("FAIL cancel_snd got=%h exp=0000", s); end
        ch_snd = '0; ch_snd[15:0] = 16'hFFFF;
        ch_vol = {8{8'd1}};
        ch_en  = 8'h01;
        do_pass(lat, s, s3);
        checks++; if (s !== 16'hFFFF) begin failures++; $display("FAIL floor_snd got=%h exp=ffff", s); end
    endtask

    task automatic test_saturation();
        int lat; logic [15:0] s, s3;
        ch_snd = {8{16'h7FFF}};
        ch_vol = {8{8'hFF}};
        ch_en  = 8'hFF;
        do_pass(lat, s, s3);
        checks++; if (s !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got=%h exp=7fff", s); end
        checks++; if (s3 !== 16'h7F7F) begin failures++; $display("FAIL sat_pos_shift3 got=%h exp=7f7f", s3); end
        ch_snd = {8{16'h8000}};
        do_pass(lat, s, s3);
        checks++; if (s !== 16'h8000) begin failures++; $display("FAIL sat_neg got=%h exp=8000", s); end
        checks++; if (s3 !== 16'h8080) begin failures++; $display("FAIL sat_neg_shift3 got=%h exp=8080", s3); end
    endtask

    task automatic test_mask_snapshot();
        int lat;
        ch_snd = {8{16'h0100}};
        ch_vol = {8{8'hFF}};
        ch_en  = 8'hA5;
        lat = -1;
        stb = 1'b1;
        tick();
        stb = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 2) begin
                ch_snd = {8{16'h7FFF}};
                ch_en  = 8'hFF;
                ch_vol = {8{8'h01}};
            end
            if (o_valid) begin
                lat = c;
                break;
            end
            tick();
        end
        checks++; if (lat !== 10) begin failures++; $display("FAIL snapshot_latency got=%0d exp=10", lat); end
        checks++; if (o_snd !== 16'h03FC) begin failures++; $display("FAIL snapshot_snd got=%h exp=03fc", o_snd); end
        tick();
    endtask

    task automatic test_overrun();
        ch_snd = {8{16'h0100}};
        ch_vol = {8{8'hFF}};
        ch_en  = 8'hFF;
        stb = 1'b1;
        tick();
        for (int c = 1; c <= 22; c++) begin
            checks++; if (o_valid !== (c == 10 || c == 21)) begin failures++; $display("FAIL overrun_valid cyc=%0d got=%b exp=%b", c, o_valid, (c == 10 || c == 21)); end
            checks++; if (o_overrun !== (c >= 5)) begin failures++; $display("FAIL overrun_flag cyc=%0d got=%b exp=%b", c, o_overrun, (c >= 5)); end
            if (c == 10 || c == 21) begin
                checks++; if (o_snd !== 16'h07F8) begin failures++; $display("FAIL overrun_snd cyc=%0d got=%h exp=07f8", c, o_snd); end
            end
            if (c == 22) begin
                checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL overrun_busy_end got=%b exp=0", o_busy); end
            end
            stb = (c == 4 || c == 11);
            tick();
        end
        stb = 1'b0;
    endtask

    task automatic test_reset_midpass();
        int lat; logic [15:0] s, s3;
        ch_snd = {8{16'h0100}};
        ch_vol = {8{8'hFF}};
        ch_en  = 8'hFF;
        stb = 1'b1;
        tick();
        stb = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        checks++; if (o_snd !== 16'h0000) begin failures++; $display("FAIL midreset_snd got=%h exp=0000", o_snd); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", o_busy); end
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL midreset_overrun got=%b exp=0", o_overrun); end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_valid cyc=%0d got=%b exp=0", c, o_valid); end
            tick();
        end
        for (int k = 0; k < 8; k++) ch_vol[8*k +: 8] = 8'(16 * (k + 1));
        do_pass(lat, s, s3);
        checks++; if (lat !== 10) begin failures++; $display("FAIL after_reset_latency got=%0d exp=10", lat); end
        checks++; if (s !== 16'h0240) begin failures++; $display("FAIL after_reset_snd got=%h exp=0240", s); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] s, s3;
        ch_snd = {8{16'hF000}};
        ch_vol = {8{8'd64}};
        ch_en  = 8'h0F;
        do_pass(lat, s, s3);
        checks++; if (s !== 16'hF000) begin failures++; $display("FAIL b2b_first got=%h exp=f000", s); end
        ch_en  = 8'hF0;
        ch_vol = {{4{8'd128}}, {4{8'd64}}};
        do_pass(lat, s, s3);
        checks++; if (lat !== 10) begin failures++; $display("FAIL b2b_latency got=%0d exp=10", lat); end
        checks++; if (s !== 16'hE000) begin failures++; $display("FAIL b2b_second got=%h exp=e000", s); end
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", o_overrun); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_cancel_floor();
        test_saturation();
        test_mask_snapshot();
        test_overrun();
        test_reset_midpass();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_mixer.md
Name: wave_mixer

Overview:
- Downstream stage of the per-channel wave sample players; consumes up to 8 signed 16-bit channel outputs and produces one mixed signed 16-bit stream for the audio DAC path.
- Each mix pass is triggered by a sample-rate strobe and captures a snapshot of all channel samples and volumes.
- One shared multiplier is time-multiplexed across channels: one channel per clock, per-channel volume, enable mask, optional master attenuation shift, output saturation.

Parameters:
- CHANNELS, 8, number of mixed channels (1..8); slot counter width is clog2(CHANNELS), minimum 1.
- MIX_SHIFT, 0, arithmetic right shift applied to the accumulated sum before saturation (0..4).

Ports:
- I_CLK  in  1  system clock.
- I_RST  in  1  synchronous active-high reset.
- I_SAMPLE_STB  in  1  single-cycle strobe; starts one mix pass.
- I_CH_SND  in  16*CHANNELS  packed signed samples; channel k occupies bits [16k+15:16k].
- I_CH_VOL  in  8*CHANNELS  packed unsigned volumes; channel k occupies bits [8k+7:8k]; 255 is near unity.
- I_CH_EN  in  CHANNELS  per-channel enable mask.
- O_SND  out  16  signed mixed sample; held between passes.
- O_VALID  out  1  one-cycle pulse when O_SND updates.
- O_BUSY  out  1  high while a pass is in progress.
- O_OVERRUN  out  1  sticky; set when a strobe arrives while busy; cleared only by reset.

Behaviour:
- Reset is synchronous and active-high on I_CLK. While I_RST is high: O_SND=0, O_VALID=0, O_BUSY=0, O_OVERRUN=0, accumulator=0, slot=0, state=IDLE.
- Reset has priority over every other event. Reset mid-pass abandons the pass with no O_VALID.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE: when I_SAMPLE_STB=1, register snapshots of I_CH_SND, I_CH_VOL and I_CH_EN; clear accumulator; set slot=0; go to RUN.
- RUN: each cycle, register product[slot] = snd * {1'b0,vol}.
  - Signed 16 x signed 9 gives 25 bits.
  - Force the product to 0 if the channel's enable bit is 0.
  - Add the previous cycle's product to the accumulator.
  - Increment slot. At slot==CHANNELS-1, go to DRAIN.
- DRAIN: accumulate the final product; go to OUT.
- OUT: compute result = sat16(acc >>> MIX_SHIFT); register it to O_SND; pulse O_VALID for this one cycle; go to IDLE.
- Arithmetic per product: term = product >>> 8, arithmetic shift (floor toward -inf), 17 bits signed.
- Accumulator: 20 bits signed; cannot overflow for 8 channels.
- Saturation: clamp to 32767 / -32768.
- Latency: strobe sampled at edge 0.
  - O_BUSY is high during cycles 1 .. CHANNELS+2.
  - O_SND and O_VALID are visible in cycle CHANNELS+2 (cycle 10 for 8 channels).
  - O_BUSY falls in the cycle after O_VALID.
- Strobe during RUN, DRAIN or OUT: ignored, sets O_OVERRUN, current pass is unaffected.
- Strobe in the cycle after the OUT cycle (state=IDLE): accepted normally.
- Input changes after the snapshot have no effect on the current pass.
- O_SND holds its last value between passes; it is not cleared when all channels are disabled (a pass with mask 0 produces 0).

Decomposition:
- Shared package (wave_pkg): constants SND_W=16, VOL_W=8, PROD_W=25, ACC_W=20, and the state enum {IDLE, RUN, DRAIN, OUT}.
- One natural sub-module: mix_sat, a combinational shift-and-saturate from ACC_W bits to 16 bits, reused by later output stages.
- Everything else is inline: FSM, slot counter, snapshot registers, product register, accumulator.

Test Plan:
- Single channel: ch0=0x1000, vol 255, mask 0x01, strobe -> O_VALID in cycle 10, O_SND=0x0FF0 (4080); O_BUSY high in cycles 1..10.
- Cancellation and rounding: ch0=+1000, ch1=-1000, vol 128, mask 0x03 -> O_SND=0. Separately, ch0=-1, vol 1 -> O_SND=0xFFFF (-1, floor).
- Saturation: all 8 channels 0x7FFF, vol 255 -> O_SND=0x7FFF. All 8 channels 0x8000, vol 255 -> O_SND=0x8000. With MIX_SHIFT=3 and all 0x7FFF -> 261112>>>3 = 32639 = 0x7F7F.
- Mask and snapshot: all channels 0x0100, vol 255, mask 0xA5; change I_CH_SND to 0x7FFF in cycle 2 -> O_SND = 4*255 = 1020 (0x03FC).
- Overrun: strobe at cycle 0 and again at cycle 4 -> single O_VALID in cycle 10, O_OVERRUN=1 from cycle 5. A strobe at cycle 11 yields the next O_VALID at cycle 21.
- Reset mid-pass: assert I_RST in cycle 5 -> O_SND=0, O_BUSY=0, O_OVERRUN=0 next cycle, no O_VALID. A strobe after deassertion produces a correct full pass.
